// File: rtl/serial_to_byte_pkg.sv
// Shared widths for the serial-to-byte assembler and its bench.
package serial_to_byte_pkg;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
endpackage

// File: rtl/serial_to_byte_if.sv
// Serial-in / byte-out handshake bundle; all_ones exists only with SERIAL_TO_BYTE_ALL_ONES_EN.
interface serial_to_byte_if;
    import serial_to_byte_pkg::*;

    logic              sin;
    logic              sin_valid;
    logic              sin_ready;
    logic [BYTE_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
    logic              all_ones;

    modport master (input sin, sin_valid, out_ready,
                    output sin_ready, out, out_valid, all_ones);
    modport slave  (output sin, sin_valid, out_ready,
                    input sin_ready, out, out_valid, all_ones);
`else
    modport master (input sin, sin_valid, out_ready,
                    output sin_ready, out, out_valid);
    modport slave  (output sin, sin_valid, out_ready,
                    input sin_ready, out, out_valid);
`endif
endinterface

// File: rtl/serial_to_byte_and8way.sv
// 8-input AND gate feeding the all_ones flag; built only with SERIAL_TO_BYTE_ALL_ONES_EN.
`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
module And8Way (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
    output logic out
);
    assign out = a & b & c & d & e & f & g & h;
endmodule
`endif

// File: rtl/serial_to_byte.sv
// Assembles LSB-first serial bits into bytes with a ready/valid output stage.
// Optional all_ones flag under SERIAL_TO_BYTE_ALL_ONES_EN.
module serial_to_byte
    import serial_to_byte_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    serial_to_byte_if.master   bus
);
    logic [BYTE_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic [BYTE_W-1:0] out_q;
    logic              out_valid_q;
    logic [BYTE_W-1:0] next_byte;
    logic              last;
    logic              accept;
    logic              load;

    assign next_byte     = {bus.sin, sr[BYTE_W-1:1]};
    assign last          = (cnt == '1);
    // Only the eighth bit can stall: it needs the output register free.
    assign bus.sin_ready = !(last && out_valid_q && !bus.out_ready);
    assign accept        = bus.sin_valid && bus.sin_ready;
    assign load          = accept && last;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            cnt         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                sr  <= next_byte;
                cnt <= cnt + CNT_W'(1);
            end
            if (load) begin
                out_q       <= next_byte;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
    logic and_out;
    logic all_ones_q;

    And8Way u_and8 (
        .a(next_byte[0]), .b(next_byte[1]), .c(next_byte[2]), .d(next_byte[3]),
        .e(next_byte[4]), .f(next_byte[5]), .g(next_byte[6]), .h(next_byte[7]),
        .out(and_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_ones_q <= 1'b0;
        end else if (load) begin
            all_ones_q <= and_out;
        end else if (out_valid_q && bus.out_ready) begin
            all_ones_q <= 1'b0;
        end
    end

    assign bus.all_ones = all_ones_q;
`endif
endmodule

// File: tb/tb_serial_to_byte.sv
// Directed self-checking bench for serial_to_byte (works with or without SERIAL_TO_BYTE_ALL_ONES_EN).
module tb_serial_to_byte;
    import serial_to_byte_pkg::*;

    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;

    serial_to_byte_if bus ();

    serial_to_byte dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit with sin_valid high across one rising edge; inputs change 1 time unit after the edge.
    task automatic send_bit(input logic b);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [BYTE_W-1:0] v);
        for (int i = 0; i < int'(BYTE_W); i++) send_bit(v[i]);
        bus.sin_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        bus.sin_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [BYTE_W-1:0] pat;
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out", 32'(bus.out), 32'h00);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
        check("rst_all_ones", 32'(bus.all_ones), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Alternating pattern, consecutive bits, consumer always ready
        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            bus.sin = pat[i];
            bus.sin_valid = 1'b1;
            #1;
            check("p55_ready", 32'(bus.sin_ready), 32'h1);
            @(posedge clk);
            #1;
        end
        bus.sin_valid = 1'b0;
        check("p55_out", 32'(bus.out), 32'h55);
        check("p55_valid", 32'(bus.out_valid), 32'h1);
`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
        check("p55_all_ones", 32'(bus.all_ones), 32'h0);
`endif
        idle(1);
        check("p55_valid_one_cycle", 32'(bus.out_valid), 32'h0);
        check("p55_out_held", 32'(bus.out), 32'h55);

        // Eight ones with sin_valid toggling every other cycle
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            if (i != 7) idle(1);
        end
        bus.sin_valid = 1'b0;
        check("pff_out", 32'(bus.out), 32'hFF);
        check("pff_valid", 32'(bus.out_valid), 32'h1);
`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
        check("pff_all_ones", 32'(bus.all_ones), 32'h1);
`endif
        idle(1);
        check("pff_valid_clear", 32'(bus.out_valid), 32'h0);
`ifdef SERIAL_TO_BYTE_ALL_ONES_EN
        check("pff_all_ones_clear", 32'(bus.all_ones), 32'h0);
`endif

        // Backpressure: A5 then 3C with consumer stalled
        bus.out_ready = 1'b0;
        send_byte(8'hA5);
        check("bp_a5_out", 32'(bus.out), 32'hA5);
        check("bp_a5_valid", 32'(bus.out_valid), 32'h1);
        pat = 8'h3C;
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        bus.sin = pat[7];
        bus.sin_valid = 1'b1;
        #1;
        check("bp_ready_drop", 32'(bus.sin_ready), 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("bp_out_hold", 32'(bus.out), 32'hA5);
        check("bp_valid_hold", 32'(bus.out_valid), 32'h1);
        check("bp_ready_still_low", 32'(bus.sin_ready), 32'h0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_rise", 32'(bus.sin_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.sin_valid = 1'b0;
        check("bp_3c_out", 32'(bus.out), 32'h3C);
        check("bp_3c_valid", 32'(bus.out_valid), 32'h1);
        idle(1);
        check("bp_3c_valid_clear", 32'(bus.out_valid), 32'h0);

        // Reset mid-byte discards partial bits
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        bus.sin_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(bus.out), 32'h00);
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h0F);
        check("post_rst_out", 32'(bus.out), 32'h0F);
        check("post_rst_valid", 32'(bus.out_valid), 32'h1);
        idle(1);

        // Long gap with sin toggling mid-byte: 1,0,1 then gap then 1,1,0,0,1 -> 9D
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.sin_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.sin = ~bus.sin;
            @(posedge clk);
            #1;
        end
        check("gap_out", 32'(bus.out), 32'h0F);
        check("gap_valid", 32'(bus.out_valid), 32'h0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("gap_no_early_load", 32'(bus.out_valid), 32'h0);
        send_bit(1'b1);
        bus.sin_valid = 1'b0;
        check("gap_out_9d", 32'(bus.out), 32'h9D);
        check("gap_valid_9d", 32'(bus.out_valid), 32'h1);
        idle(2);

        // out_ready activity while idle must not disturb outputs
        bus.out_ready = 1'b0;
        idle(1);
        bus.out_ready = 1'b1;
        idle(1);
        check("idle_ready_out", 32'(bus.out), 32'h9D);
        check("idle_ready_valid", 32'(bus.out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
